// File: rtl/lsu_if.sv
// lsu_if: core request/response and xbus signals grouped for the lsu.
// slave is the lsu view; master is the core + memory view.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        xbus_cs;
    logic        xbus_we;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr;
    logic [31:0] xbus_wdata;
    logic [31:0] xbus_rdata;
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, xbus_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, xbus_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata
    );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit bridging core requests onto a word-addressed, byte-enabled xbus.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word and reserved size as errors.
module lsu #(
    parameter int BUS_LAT = 1
) (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK} state_t;
    state_t      r_state, w_next;
    logic [2:0]  r_cnt, w_cnt;
    logic [1:0]  r_off, r_size;
    logic        r_uns, r_err;
    logic        w_acc, w_err, w_go, w_done;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    always_comb begin
        w_acc = bus.req_valid && (r_state == IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
        w_err = (bus.req_size == 2'b11) || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
        w_err = 1'b0;
`endif
        w_go = w_acc && !w_err;
        w_be = (bus.req_size == 2'b00) ? 4'b0001 << bus.req_addr[1:0] :
               (bus.req_size == 2'b01) ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        bus.req_ready  = (r_state == IDLE);
        bus.xbus_cs    = w_go;
        bus.xbus_we    = w_go && bus.req_we;
        bus.xbus_be    = w_go ? w_be : 4'b0000;
        bus.xbus_addr  = w_go ? {bus.req_addr[31:2], 2'b00} : 32'd0;
        bus.xbus_wdata = !w_go ? 32'd0 :
                         (bus.req_size == 2'b00) ? {4{bus.req_wdata[7:0]}} :
                         (bus.req_size == 2'b01) ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
        // Lane selection uses only the fields captured at accept time.
        w_done = (r_state == RD_WAIT) && (r_cnt == 3'(BUS_LAT));
        w_byte = bus.xbus_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? bus.xbus_rdata[31:16] : bus.xbus_rdata[15:0];
        bus.resp_valid = (r_state == WR_ACK) || w_done;
`ifdef LSU_MISALIGN_TRAP_EN
        bus.resp_err   = (r_state == WR_ACK) && r_err;
`else
        bus.resp_err   = 1'b0;
`endif
        bus.resp_rdata = !w_done ? 32'd0 :
                         (r_size == 2'b00) ? {{24{!r_uns && w_byte[7]}}, w_byte} :
                         (r_size == 2'b01) ? {{16{!r_uns && w_half[15]}}, w_half} : bus.xbus_rdata;
    end
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        case (r_state)
            IDLE: begin
                w_next = !w_acc ? IDLE : (w_err || bus.req_we) ? WR_ACK : RD_WAIT;
                w_cnt  = w_acc ? 3'd1 : 3'd0;
            end
            RD_WAIT: begin
                w_next = w_done ? IDLE : RD_WAIT;
                w_cnt  = w_done ? 3'd0 : r_cnt + 3'd1;
            end
            WR_ACK:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_off   <= 2'd0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            if (w_acc) begin
                r_off  <= bus.req_addr[1:0];
                r_size <= bus.req_size;
                r_uns  <= bus.req_unsigned;
                r_err  <= w_err;
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: vector table plus response scoreboard for lsu at BUS_LAT 1,
// with hand sequences for BUS_LAT 3 timing and BUS_LAT 2 reset abort.
module tb_lsu;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    lsu_if b1();
    lsu_if b2();
    lsu_if b3();
    lsu #(.BUS_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    lsu #(.BUS_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    lsu #(.BUS_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Synchronous-read memory for the BUS_LAT=1 instance; read data holds until the next read.
    logic [31:0] mem [0:255];
    logic [31:0] r_rd;
    always @(posedge clk) begin
        if (b1.xbus_cs) begin
            if (b1.xbus_we) begin
                for (int i = 0; i < 4; i++)
                    if (b1.xbus_be[i]) mem[b1.xbus_addr[9:2]][8*i +: 8] <= b1.xbus_wdata[8*i +: 8];
            end else begin
                r_rd <= mem[b1.xbus_addr[9:2]];
            end
        end
    end
    assign b1.xbus_rdata = r_rd;
    assign b2.xbus_rdata = 32'h80FF1234;
    assign b3.xbus_rdata = 32'h80FF1234;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cs;
        logic [3:0]  be;
        logic [31:0] xaddr;
        logic [31:0] xwdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    vec_t tv[18];
    exp_t sbq[$];

    function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic cs, logic [3:0] be, logic [31:0] xaddr,
                                logic [31:0] xwdata, logic [31:0] rdata, logic err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.cs = cs; v.be = be; v.xaddr = xaddr; v.xwdata = xwdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && b1.resp_valid) begin
            if (sbq.size() == 0) begin
                chk("b1 spurious resp_valid", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("b1 resp {rdata,err,cycle}", {b1.resp_rdata, b1.resp_err, 32'(cyc)},
                    {e.rdata, e.err, 32'(e.due)});
            end
        end
    end

    task automatic apply(vec_t v, int idx);
        int w;
        w = 0;
        while (!b1.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!b1.req_ready) chk($sformatf("vec%0d ready timeout", idx), 128'd0, 128'd1);
        b1.req_valid = 1'b1;
        b1.req_we = v.we;
        b1.req_size = v.size;
        b1.req_unsigned = v.uns;
        b1.req_addr = v.addr;
        b1.req_wdata = v.wdata;
        #1;
        chk($sformatf("vec%0d xbus {cs,we,be,addr,wdata}", idx),
            {b1.xbus_cs, b1.xbus_we, b1.xbus_be, b1.xbus_addr, b1.xbus_wdata},
            {v.cs, v.cs & v.we, v.be, v.xaddr, v.xwdata});
        sbq.push_back('{v.rdata, v.err, cyc + 1});
        @(posedge clk);
        #1;
        b1.req_addr = $urandom;
        b1.req_size = ~v.size;
        b1.req_unsigned = ~v.uns;
        @(negedge clk);
        chk($sformatf("vec%0d busy {ready,cs,be,addr,wdata}", idx),
            {b1.req_ready, b1.xbus_cs, b1.xbus_we, b1.xbus_be, b1.xbus_addr, b1.xbus_wdata}, 128'd0);
        b1.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        {b1.req_valid, b1.req_we, b1.req_size, b1.req_unsigned, b1.req_addr, b1.req_wdata} = '0;
        {b2.req_valid, b2.req_we, b2.req_size, b2.req_unsigned, b2.req_addr, b2.req_wdata} = '0;
        {b3.req_valid, b3.req_we, b3.req_size, b3.req_unsigned, b3.req_addr, b3.req_wdata} = '0;
        tv[0]  = mk(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 1, 4'b1111, 32'h100, 32'hDEADBEEF, 0, 0);
        tv[1]  = mk(1, 2'b00, 0, 32'h103, 32'h0000005A, 1, 4'b1000, 32'h100, 32'h5A5A5A5A, 0, 0);
        tv[2]  = mk(0, 2'b10, 0, 32'h100, 0, 1, 4'b1111, 32'h100, 0, 32'h5AADBEEF, 0);
        tv[3]  = mk(1, 2'b10, 0, 32'h100, 32'h80FF1234, 1, 4'b1111, 32'h100, 32'h80FF1234, 0, 0);
        tv[4]  = mk(0, 2'b00, 0, 32'h103, 0, 1, 4'b1000, 32'h100, 0, 32'hFFFFFF80, 0);
        tv[5]  = mk(0, 2'b00, 1, 32'h103, 0, 1, 4'b1000, 32'h100, 0, 32'h00000080, 0);
        tv[6]  = mk(0, 2'b01, 0, 32'h102, 0, 1, 4'b1100, 32'h100, 0, 32'hFFFF80FF, 0);
        tv[7]  = mk(0, 2'b01, 1, 32'h102, 0, 1, 4'b1100, 32'h100, 0, 32'h000080FF, 0);
        tv[8]  = mk(0, 2'b00, 0, 32'h102, 0, 1, 4'b0100, 32'h100, 0, 32'hFFFFFFFF, 0);
        tv[9]  = mk(0, 2'b00, 1, 32'h101, 0, 1, 4'b0010, 32'h100, 0, 32'h00000012, 0);
        tv[10] = mk(0, 2'b01, 0, 32'h100, 0, 1, 4'b0011, 32'h100, 0, 32'h00001234, 0);
        tv[11] = mk(1, 2'b10, 0, 32'h200, 32'h11223344, 1, 4'b1111, 32'h200, 32'h11223344, 0, 0);
        tv[12] = mk(1, 2'b01, 0, 32'h202, 32'h0000ABCD, 1, 4'b1100, 32'h200, 32'hABCDABCD, 0, 0);
        tv[13] = mk(0, 2'b10, 0, 32'h200, 0, 1, 4'b1111, 32'h200, 0, 32'hABCD3344, 0);
        tv[14] = TRAP ? mk(0, 2'b10, 0, 32'h101, 0, 0, 4'b0000, 0, 0, 0, 1)
                      : mk(0, 2'b10, 0, 32'h101, 0, 1, 4'b1111, 32'h100, 0, 32'h80FF1234, 0);
        tv[15] = TRAP ? mk(0, 2'b11, 0, 32'h100, 0, 0, 4'b0000, 0, 0, 0, 1)
                      : mk(0, 2'b11, 0, 32'h100, 0, 1, 4'b1111, 32'h100, 0, 32'h80FF1234, 0);
        tv[16] = TRAP ? mk(0, 2'b01, 0, 32'h101, 0, 0, 4'b0000, 0, 0, 0, 1)
                      : mk(0, 2'b01, 0, 32'h101, 0, 1, 4'b0011, 32'h100, 0, 32'h00001234, 0);
        tv[17] = TRAP ? mk(1, 2'b01, 0, 32'h105, 32'h00007777, 0, 4'b0000, 0, 0, 0, 1)
                      : mk(1, 2'b01, 0, 32'h105, 32'h00007777, 1, 4'b0011, 32'h104, 32'h77777777, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset {resp_valid,resp_err,resp_rdata}", {b1.resp_valid, b1.resp_err, b1.resp_rdata}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset release {ready,resp_valid,cs}", {b1.req_ready, b1.resp_valid, b1.xbus_cs}, {1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 18; i++) apply(tv[i], i);
        repeat (3) @(negedge clk);
        chk("b1 outstanding responses", 128'(sbq.size()), 128'd0);

        // BUS_LAT=3: response only at T+3, no accept while busy even with a request held.
        b3.req_valid = 1'b1;
        b3.req_size = 2'b10;
        b3.req_addr = 32'h100;
        #1;
        chk("lat3 accept cs", 128'(b3.xbus_cs), 128'd1);
        @(posedge clk);
        #1;
        b3.req_size = 2'b00;
        b3.req_addr = 32'h203;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("lat3 T+%0d {ready,resp_valid,cs}", k),
                {b3.req_ready, b3.resp_valid, b3.xbus_cs},
                {k == 4, k == 3, 1'b0});
            if (k == 3) begin
                chk("lat3 rdata/err", {b3.resp_rdata, b3.resp_err}, {32'h80FF1234, 1'b0});
                b3.req_valid = 1'b0;
            end
        end

        // BUS_LAT=2: reset in T+1 drops the in-flight load.
        @(negedge clk);
        b2.req_valid = 1'b1;
        b2.req_size = 2'b10;
        b2.req_addr = 32'h100;
        #1;
        chk("lat2 accept cs", 128'(b2.xbus_cs), 128'd1);
        @(posedge clk);
        #1;
        b2.req_valid = 1'b0;
        rst_n = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            pulses += int'(b2.resp_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("lat2 ready after release", 128'(b2.req_ready), 128'd1);
        repeat (5) begin
            pulses += int'(b2.resp_valid);
            @(negedge clk);
        end
        chk("lat2 resp pulses after reset", 128'(pulses), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter BUS_LAT, default 1, meaning xbus read latency in cycles from the chip-select cycle; legal range 1..4.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  lsu accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  input  1  load zero-extend when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misalignment/reserved-size error, valid with resp_valid.
REQ-014 SHALL have ports xbus_cs, xbus_we (output 1), xbus_be (output 4), xbus_addr, xbus_wdata (output 32), xbus_rdata (input 32): word-addressed, byte-enabled, synchronous-read memory bus.

Function
REQ-015 SHALL implement states IDLE, RD_WAIT, WR_ACK; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request in cycle T when req_valid && req_ready, driving xbus_* combinationally in T; in every other cycle xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata SHALL be 0.
REQ-017 SHALL drive xbus_addr = {req_addr[31:2], 2'b00} and xbus_we = req_we.
REQ-018 SHALL drive xbus_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<(2*addr[1]); word 4'b1111; loads drive the same be.
REQ-019 SHALL drive xbus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-020 SHALL on store accept go to WR_ACK; resp_valid = 1 in T+1, resp_rdata = 0, then IDLE.
REQ-021 SHALL on load accept capture addr[1:0], size, unsigned, go to RD_WAIT, count cycles, and assert resp_valid in cycle T+BUS_LAT, then IDLE in T+BUS_LAT+1.
REQ-022 SHALL form resp_rdata in the response cycle from xbus_rdata: byte lane addr[1:0], half lane addr[1], sign- or zero-extended to 32 bits per captured unsigned flag; word passes through.
REQ-023 SHALL ignore req_* changes while not in IDLE; captured fields alone govern the response.
REQ-024 SHALL not accept a new request in the response cycle; back-to-back load throughput is one per BUS_LAT+1 cycles.

Reset
REQ-025 SHALL on rst_n = 0 immediately force state IDLE, counter 0, captured fields 0, resp_valid 0, resp_err 0, resp_rdata 0, req_ready 1 after release.
REQ-026 SHALL discard any in-flight load or store ack on reset; no resp_valid SHALL follow release for that request.

Configuration
REQ-027 SHALL with macro LSU_MISALIGN_TRAP_EN defined flag half with addr[0]=1, word with addr[1:0]!=0, and size 11 as errors: xbus_cs stays 0, state WR_ACK, resp_valid and resp_err = 1 in T+1, resp_rdata = 0.
REQ-028 SHALL without LSU_MISALIGN_TRAP_EN tie resp_err to 0, ignore addr[0] for half and addr[1:0] for word, and treat size 11 as word.

Verification
REQ-029 SHALL cover: sw addr 0x100 wdata 0xDEADBEEF -> T: cs=1, we=1, be=1111, addr 0x100; T+1 resp_valid=1, rdata 0.
REQ-030 SHALL cover: sb addr 0x103 wdata 0x0000005A -> be=1000, xbus_wdata 0x5A5A5A5A.
REQ-031 SHALL cover: memory word 0x80FF1234 at 0x100, BUS_LAT=1: lb 0x103 -> 0xFFFFFF80; lbu 0x103 -> 0x00000080; lh 0x102 -> 0xFFFF80FF; lhu 0x102 -> 0x000080FF; resp at T+1.
REQ-032 SHALL cover: lw 0x101 -> with macro no cs, resp_err=1 at T+1; without macro reads 0x100, resp_err=0.
REQ-033 SHALL cover: BUS_LAT=3 lw at T -> resp_valid only at T+3, req_ready 0 in T+1..T+3.
REQ-034 SHALL cover: BUS_LAT=2 load, rst_n low in T+1 -> no resp_valid ever, req_ready 1 first cycle after release.
